ar0135_cfg_sequencer: RTL and testbench

AR0135_CFG_SEQUENCER -- requirements
Module: ar0135_cfg_sequencer

---
 rtl/ar0135_cfg_sequencer.sv | 158 +++++++++++++++
 tb/tb_ar0135_cfg_sequencer.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ar0135_cfg_sequencer.sv
// Walks a register LUT and issues it to the AR0135 sensor over an I2C master.
// Entry 0 can be a chip-ID read-and-compare; address 0x0000 entries are delays.
module ar0135_cfg_sequencer #(
    parameter logic [15:0] DELAY_CYCLES  = 16'd20000,
    parameter int          MAX_RETRY     = 2,
    parameter int          CHIP_ID_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  lut_index,
    input  logic [31:0] lut_data,
    input  logic [7:0]  lut_size,
    output logic        i2c_req,
    output logic        i2c_rd,
    output logic [15:0] i2c_addr,
    output logic [15:0] i2c_wdata,
    input  logic        i2c_ack,
    input  logic        i2c_nack,
    input  logic [15:0] i2c_rdata,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [15:0] chip_id,
    output logic [2:0]  state_dbg
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        XFER  = 3'd2,
        DELAY = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5,
        FAIL  = 3'd6
    } state_t;

    localparam logic [7:0] MAX_RETRY_W = 8'(MAX_RETRY);
    localparam bit         READ_ID     = (CHIP_ID_CHECK != 0);

    state_t      state;
    logic [7:0]  retry_cnt;
    logic [15:0] delay_cnt;
    logic [15:0] entry_val;

    assign state_dbg = state;

    // Request handshake: i2c_req rises with rd/addr/wdata already valid and all
    // four stay frozen until the master returns a one-cycle i2c_ack (with
    // i2c_nack alongside on a slave NACK); i2c_req falls on the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            lut_index <= 8'd0;
            retry_cnt <= 8'd0;
            delay_cnt <= 16'd0;
            entry_val <= 16'd0;
            i2c_req   <= 1'b0;
            i2c_rd    <= 1'b0;
            i2c_addr  <= 16'd0;
            i2c_wdata <= 16'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            fail      <= 1'b0;
            chip_id   <= 16'd0;
        end else begin
            case (state)
                IDLE, DONE, FAIL: begin
                    if (start) begin
                        lut_index <= 8'd0;
                        retry_cnt <= 8'd0;
                        delay_cnt <= 16'd0;
                        fail      <= 1'b0;
                        if (lut_size == 8'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                            busy  <= 1'b0;
                        end else begin
                            state <= FETCH;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end

                FETCH: begin
                    entry_val <= lut_data[15:0];
                    if (lut_data[31:16] == 16'h0000) begin
                        state     <= DELAY;
                        delay_cnt <= 16'd0;
                    end else begin
                        state     <= XFER;
                        i2c_req   <= 1'b1;
                        i2c_rd    <= READ_ID && (lut_index == 8'd0);
                        i2c_addr  <= lut_data[31:16];
                        i2c_wdata <= lut_data[15:0];
                    end
                end

                XFER: begin
                    if (i2c_ack) begin
                        i2c_req <= 1'b0;
                        if (i2c_rd) begin
                            chip_id <= i2c_rdata;
                            if (i2c_nack || (i2c_rdata != entry_val)) begin
                                state <= FAIL;
                                busy  <= 1'b0;
                                fail  <= 1'b1;
                            end else begin
                                state <= NEXT;
                            end
                        end else if (!i2c_nack) begin
                            state <= NEXT;
                        end else if (retry_cnt < MAX_RETRY_W) begin
                            // Re-issue goes back through FETCH so i2c_req drops for a cycle.
                            retry_cnt <= retry_cnt + 8'd1;
                            state     <= FETCH;
                        end else begin
                            state <= FAIL;
                            busy  <= 1'b0;
                            fail  <= 1'b1;
                        end
                    end
                end

                DELAY: begin
                    if (({1'b0, delay_cnt} + 17'd1) >= {1'b0, DELAY_CYCLES}) begin
                        state <= NEXT;
                    end else begin
                        delay_cnt <= delay_cnt + 16'd1;
                    end
                end

                NEXT: begin
                    // Compare in 9 bits so a shrunken lut_size can never push the index past the end.
                    if (({1'b0, lut_index} + 9'd1) >= {1'b0, lut_size}) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        lut_index <= lut_index + 8'd1;
                        retry_cnt <= 8'd0;
                        state     <= FETCH;
                    end
                end

                default: begin
                    state   <= IDLE;
                    i2c_req <= 1'b0;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    fail    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ar0135_cfg_sequencer.sv
// Directed bench for ar0135_cfg_sequencer: LUT in an array, I2C slave model on the
// falling edge, observed transactions collected for per-scenario comparison.
module tb_ar0135_cfg_sequencer;

    localparam logic [15:0] DLY = 16'd8;
    localparam logic [2:0] S_IDLE = 3'd0, S_XFER = 3'd2, S_DELAY = 3'd3;
    localparam logic [2:0] S_DONE = 3'd5, S_FAIL = 3'd6;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  lut_index;
    logic [31:0] lut_data;
    logic [7:0]  lut_size = 8'd24;
    logic        i2c_req, i2c_rd;
    logic [15:0] i2c_addr, i2c_wdata;
    logic        i2c_ack, i2c_nack;
    logic [15:0] i2c_rdata;
    logic        busy, done, fail;
    logic [15:0] chip_id;
    logic [2:0]  state_dbg;

    logic [31:0] lut_mem [0:255];
    logic        slave_ack = 1'b0, slave_nack = 1'b0;
    logic        force_ack = 1'b0, force_nack = 1'b0;
    logic [15:0] rdata_val = 16'h0554;
    logic [15:0] nack_addr = 16'h302C;
    int          nack_left = 0;
    int          hold_idx = -1;
    int          wait_cnt = 0;
    bit          acked = 1'b0;
    logic        prev_req = 1'b0;
    logic [32:0] prev_fields = '0;
    int          run = 0;

    logic [32:0] obs_q[$];
    logic [32:0] exp_q[$];
    int          dly_runs[$];
    int          stab_err = 0, dly_req_err = 0, both_err = 0, idx_err = 0;
    int          checks = 0, failures = 0;

    assign lut_data  = lut_mem[lut_index];
    assign i2c_ack   = slave_ack | force_ack;
    assign i2c_nack  = slave_nack | force_nack;
    assign i2c_rdata = rdata_val;

    always #5 clk = ~clk;

    ar0135_cfg_sequencer #(.DELAY_CYCLES(DLY), .MAX_RETRY(2), .CHIP_ID_CHECK(1)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .lut_index(lut_index),
        .lut_data(lut_data), .lut_size(lut_size), .i2c_req(i2c_req), .i2c_rd(i2c_rd),
        .i2c_addr(i2c_addr), .i2c_wdata(i2c_wdata), .i2c_ack(i2c_ack), .i2c_nack(i2c_nack),
        .i2c_rdata(i2c_rdata), .busy(busy), .done(done), .fail(fail), .chip_id(chip_id),
        .state_dbg(state_dbg)
    );

    // Slave model and monitors, all sampled away from the rising edge.
    always @(negedge clk) begin
        slave_ack  = 1'b0;
        slave_nack = 1'b0;
        if (!i2c_req) begin
            acked    = 1'b0;
            wait_cnt = 0;
        end else if (!acked && (hold_idx < 0 || int'(lut_index) != hold_idx)) begin
            if (wait_cnt >= 1) begin
                slave_ack = 1'b1;
                acked     = 1'b1;
                if (!i2c_rd && i2c_addr == nack_addr && nack_left > 0) begin
                    slave_nack = 1'b1;
                    nack_left--;
                end
                obs_q.push_back({i2c_rd, i2c_addr, i2c_wdata});
            end else begin
                wait_cnt++;
            end
        end
        if (i2c_req && prev_req && ({i2c_rd, i2c_addr, i2c_wdata} != prev_fields)) stab_err++;
        prev_req    = i2c_req;
        prev_fields = {i2c_rd, i2c_addr, i2c_wdata};
        if (state_dbg == S_DELAY) begin
            run++;
            if (i2c_req) dly_req_err++;
        end else if (run > 0) begin
            dly_runs.push_back(run);
            run = 0;
        end
        if (done && fail) both_err++;
        if (busy && lut_index >= lut_size) idx_err++;
    end

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_end(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic build_exp(input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++)
            if (lut_mem[i][31:16] != 16'h0000) exp_q.push_back({(i == 0), lut_mem[i]});
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (i2c_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", i2c_req); end
        checks++; if ({i2c_rd, i2c_addr, i2c_wdata} !== 33'd0) begin failures++; $display("FAIL reset_bus: got %h want 0", {i2c_rd, i2c_addr, i2c_wdata}); end
        checks++; if (lut_index !== 8'd0) begin failures++; $display("FAIL reset_index: got %0d want 0", lut_index); end
        checks++; if ({busy, done, fail} !== 3'b000) begin failures++; $display("FAIL reset_flags: got %b want 000", {busy, done, fail}); end
        checks++; if (chip_id !== 16'd0) begin failures++; $display("FAIL reset_chip_id: got %h want 0000", chip_id); end
        checks++; if (state_dbg !== S_IDLE) begin failures++; $display("FAIL reset_state: got %0d want %0d", state_dbg, S_IDLE); end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (state_dbg !== S_IDLE || i2c_req !== 1'b0) begin failures++; $display("FAIL idle_after_reset: state %0d req %b", state_dbg, i2c_req); end
    endtask

    task automatic test_full_pass();
        bit ok;
        obs_q.delete();
        dly_runs.delete();
        rdata_val = 16'h0554;
        build_exp(24);
        pulse_start();
        wait_end(3000, ok);
        checks++; if (!ok) begin failures++; $display("FAIL full_timeout: done/fail never set"); end
        checks++; if ({done, fail, busy} !== 3'b100) begin failures++; $display("FAIL full_flags: got done/fail/busy %b want 100", {done, fail, busy}); end
        checks++; if (chip_id !== 16'h0554) begin failures++; $display("FAIL full_chip_id: got %h want 0554", chip_id); end
        checks++; if (lut_index !== 8'd23) begin failures++; $display("FAIL full_last_index: got %0d want 23", lut_index); end
        checks++; if (obs_q.size() != 22) begin failures++; $display("FAIL full_txn_count: got %0d want 22", obs_q.size()); end
        for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++) begin
            checks++;
            if (obs_q[k] !== exp_q[k]) begin failures++; $display("FAIL full_txn[%0d]: got %h want %h", k, obs_q[k], exp_q[k]); end
        end
        checks++; if (dly_runs.size() != 2) begin failures++; $display("FAIL full_delay_count: got %0d want 2", dly_runs.size()); end
        foreach (dly_runs[k]) begin
            checks++;
            if (dly_runs[k] != int'(DLY)) begin failures++; $display("FAIL full_delay_len[%0d]: got %0d want %0d", k, dly_runs[k], DLY); end
        end
        checks++; if (dly_req_err != 0) begin failures++; $display("FAIL full_req_in_delay: got %0d want 0", dly_req_err); end
        checks++; if (stab_err != 0) begin failures++; $display("FAIL full_bus_stable: got %0d want 0", stab_err); end
    endtask

    task automatic test_chip_id_mismatch();
        bit ok;
        obs_q.delete();
        rdata_val = 16'h0555;
        pulse_start();
        wait_end(500, ok);
        checks++; if (!ok) begin failures++; $display("FAIL id_timeout: done/fail never set"); end
        checks++; if ({done, fail, busy} !== 3'b010) begin failures++; $display("FAIL id_flags: got done/fail/busy %b want 010", {done, fail, busy}); end
        checks++; if (lut_index !== 8'd0) begin failures++; $display("FAIL id_index: got %0d want 0", lut_index); end
        checks++; if (chip_id !== 16'h0555) begin failures++; $display("FAIL id_chip_id: got %h want 0555", chip_id); end
        repeat (10) @(negedge clk);
        checks++; if (obs_q.size() != 1) begin failures++; $display("FAIL id_txn_count: got %0d want 1", obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 33'h1_3000_0554) begin failures++; $display("FAIL id_read_txn: got %h want 130000554", obs_q[0]); end
        end
        checks++; if (state_dbg !== S_FAIL || i2c_req !== 1'b0) begin failures++; $display("FAIL id_stays_failed: state %0d req %b", state_dbg, i2c_req); end
        rdata_val = 16'h0554;
    endtask

    task automatic test_nack_retry();
        bit ok;
        int c;
        obs_q.delete();
        nack_left = 2;
        pulse_start();
        wait_end(3000, ok);
        c = 0;
        foreach (obs_q[k]) if (obs_q[k][31:16] == 16'h302C) c++;
        checks++; if (!ok || done !== 1'b1 || fail !== 1'b0) begin failures++; $display("FAIL nack2_done: ok %b done %b fail %b want 1 1 0", ok, done, fail); end
        checks++; if (c != 3) begin failures++; $display("FAIL nack2_302c_reqs: got %0d want 3", c); end
        checks++; if (obs_q.size() != 24) begin failures++; $display("FAIL nack2_txn_count: got %0d want 24", obs_q.size()); end
        obs_q.delete();
        nack_left = 3;
        pulse_start();
        wait_end(3000, ok);
        c = 0;
        foreach (obs_q[k]) if (obs_q[k][31:16] == 16'h302C) c++;
        checks++; if (!ok || {done, fail} !== 2'b01) begin failures++; $display("FAIL nack3_fail: ok %b done/fail %b want 01", ok, {done, fail}); end
        checks++; if (lut_index !== 8'd5) begin failures++; $display("FAIL nack3_index: got %0d want 5", lut_index); end
        checks++; if (c != 3) begin failures++; $display("FAIL nack3_302c_reqs: got %0d want 3", c); end
        checks++; if (obs_q.size() != 7) begin failures++; $display("FAIL nack3_txn_count: got %0d want 7", obs_q.size()); end
        nack_left = 0;
    endtask

    task automatic test_reset_in_xfer();
        bit ok, found, req_seen;
        obs_q.delete();
        hold_idx = 7;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (i2c_req && lut_index == 8'd7 && state_dbg == S_XFER) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin failures++; $display("FAIL rst_xfer_reach: entry 7 transfer not seen"); end
        rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        checks++; if (i2c_req !== 1'b0 || state_dbg !== S_IDLE) begin failures++; $display("FAIL rst_xfer_abort: req %b state %0d want 0 %0d", i2c_req, state_dbg, S_IDLE); end
        checks++; if (lut_index !== 8'd0 || busy !== 1'b0) begin failures++; $display("FAIL rst_xfer_regs: index %0d busy %b want 0 0", lut_index, busy); end
        hold_idx = -1;
        req_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i2c_req) req_seen = 1'b1;
        end
        checks++; if (req_seen || obs_q.size() != 6) begin failures++; $display("FAIL rst_xfer_quiet: req_seen %b txns %0d want 0 6", req_seen, obs_q.size()); end
        obs_q.delete();
        pulse_start();
        wait_end(3000, ok);
        checks++; if (!ok || done !== 1'b1 || obs_q.size() != 22) begin failures++; $display("FAIL rst_xfer_restart: done %b txns %0d want 1 22", done, obs_q.size()); end
        if (obs_q.size() > 0) begin
            checks++; if (obs_q[0] !== 33'h1_3000_0554) begin failures++; $display("FAIL rst_xfer_first: got %h want 130000554", obs_q[0]); end
        end
    endtask

    task automatic test_ignored_inputs();
        bit ok;
        @(negedge clk);
        force_ack = 1'b1; force_nack = 1'b1; rdata_val = 16'hBEEF;
        @(negedge clk);
        force_ack = 1'b0; force_nack = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== S_DONE || done !== 1'b1 || chip_id !== 16'h0554) begin failures++; $display("FAIL stray_ack_done: state %0d done %b id %h want %0d 1 0554", state_dbg, done, chip_id, S_DONE); end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        force_ack = 1'b1; force_nack = 1'b0;
        @(negedge clk) force_ack = 1'b0;
        @(negedge clk);
        checks++; if (state_dbg !== S_IDLE || chip_id !== 16'd0 || i2c_req !== 1'b0) begin failures++; $display("FAIL stray_ack_idle: state %0d id %h req %b want 0 0000 0", state_dbg, chip_id, i2c_req); end
        rdata_val = 16'h0554;
        obs_q.delete();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            start = busy && (lut_index == 8'd10 || lut_index == 8'd12 || lut_index == 8'd15);
            if (done || fail) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
        checks++; if (!ok || done !== 1'b1 || lut_index !== 8'd23) begin failures++; $display("FAIL busy_start: done %b index %0d want 1 23", done, lut_index); end
        checks++; if (obs_q.size() != 22) begin failures++; $display("FAIL busy_start_txns: got %0d want 22", obs_q.size()); end
    endtask

    task automatic test_empty_lut();
        obs_q.delete();
        lut_size = 8'd0;
        pulse_start();
        checks++; if ({done, fail, busy} !== 3'b100 || state_dbg !== S_DONE) begin failures++; $display("FAIL empty_done: done/fail/busy %b state %0d want 100 %0d", {done, fail, busy}, state_dbg, S_DONE); end
        checks++; if (i2c_req !== 1'b0) begin failures++; $display("FAIL empty_req: got %b want 0", i2c_req); end
        repeat (5) @(negedge clk);
        checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL empty_txns: got %0d want 0", obs_q.size()); end
        lut_size = 8'd24;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) lut_mem[i] = {16'h3100 + 16'(2 * i), 16'h1000 + 16'(i)};
        lut_mem[0]  = 32'h3000_0554;
        lut_mem[3]  = 32'h0000_0000;
        lut_mem[12] = 32'h0000_0000;
        lut_mem[5]  = 32'h302C_00A5;

        test_reset();
        test_full_pass();
        test_chip_id_mismatch();
        test_nack_retry();
        test_reset_in_xfer();
        test_ignored_inputs();
        test_empty_lut();

        checks++; if (both_err != 0) begin failures++; $display("FAIL done_and_fail: got %0d cycles want 0", both_err); end
        checks++; if (idx_err != 0) begin failures++; $display("FAIL index_range: got %0d cycles want 0", idx_err); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
